imem_loader: RTL and testbench

Serial boot loader that fills instruction memory while holding the CPU in reset. It receives an 8N1 UART byte stream, checks a framed program image, assembles big-endian 32-bit instruction words and writes them to consecutive instruction-memory addresses starting at 0. When the checksum verifies, it releases the CPU reset. It sits between the board serial pin and the write port of `instruction_memory`, and drives the CPU's active-low `reset`.

---
 rtl/imem_loader.sv | 212 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// UART boot loader: receives a framed program image, writes it to instruction
// memory from address 0, and releases the CPU reset once the checksum matches.
module imem_loader #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int PC_ADDR_WIDTH = 8,
  parameter int WORD_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  output logic                     wr_en,
  output logic [PC_ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0]    wr_data,
  output logic                     cpu_reset,
  output logic                     done,
  output logic                     err
);
  // state   | meaning
  // R_IDLE  | line idle, waiting for a falling edge
  // R_START | timing to mid start bit, rejecting glitches
  // R_DATA  | sampling 8 data bits, LSB first
  // R_STOP  | sampling stop bit; after a framing error, waiting for line high
  // F_SYNC  | discarding bytes until 0xA5
  // F_LEN   | expecting word count N (0 is an error)
  // F_DATA  | assembling big-endian words and writing them
  // F_CSUM  | comparing the XOR checksum byte
  // F_DONE  | image loaded, CPU released
  // F_ERR   | load failed, CPU held
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [2:0] {F_SYNC, F_LEN, F_DATA, F_CSUM, F_DONE, F_ERR} fr_state_e;

  logic rx_s1_q, rx_s2_q, rx_prev_q;

  rx_state_e         rstate_q, rstate_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              brk_q, brk_d;
  logic              byte_valid_q, byte_valid_d;
  logic              rx_ferr;

  fr_state_e                 fstate_q, fstate_d;
  logic [7:0]                words_left_q, words_left_d;
  logic [1:0]                byte_idx_q, byte_idx_d;
  logic [7:0]                csum_q, csum_d;
  logic [WORD_WIDTH-9:0]     word_q, word_d;
  logic [PC_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                      wr_en_q, wr_en_d;
  logic [PC_ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [WORD_WIDTH-1:0]     wr_data_q, wr_data_d;

  always_comb begin
    rstate_d     = rstate_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    brk_d        = brk_q;
    byte_valid_d = 1'b0;
    rx_ferr      = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rstate_d = R_START;
          cnt_d    = HALF_LAST;
        end
      end
      R_START: begin
        if (cnt_q == '0) begin
          if (rx_s2_q) begin
            rstate_d = R_IDLE;
          end else begin
            rstate_d  = R_DATA;
            cnt_d     = BIT_LAST;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == '0) begin
          shreg_d   = {rx_s2_q, shreg_q[7:1]};
          cnt_d     = BIT_LAST;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) rstate_d = R_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      R_STOP: begin
        if (brk_q) begin
          if (rx_s2_q) begin
            brk_d    = 1'b0;
            rstate_d = R_IDLE;
          end
        end else if (cnt_q == '0) begin
          if (rx_s2_q) begin
            byte_valid_d = 1'b1;
            rstate_d     = R_IDLE;
          end else begin
            rx_ferr = 1'b1;
            brk_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Framing errors act in the same cycle as the failed stop sample.
  always_comb begin
    fstate_d     = fstate_q;
    words_left_d = words_left_q;
    byte_idx_d   = byte_idx_q;
    csum_d       = csum_q;
    word_d       = word_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (rx_ferr && fstate_q != F_DONE) begin
      fstate_d = F_ERR;
    end else if (byte_valid_q) begin
      case (fstate_q)
        F_SYNC: if (shreg_q == SYNC_BYTE) fstate_d = F_LEN;
        F_LEN: begin
          if (shreg_q == 8'd0) begin
            fstate_d = F_ERR;
          end else begin
            words_left_d = shreg_q;
            byte_idx_d   = '0;
            csum_d       = '0;
            addr_d       = '0;
            fstate_d     = F_DATA;
          end
        end
        F_DATA: begin
          word_d     = {word_q[WORD_WIDTH-17:0], shreg_q};
          csum_d     = csum_q ^ shreg_q;
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == 2'd3) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = addr_q;
            wr_data_d    = {word_q, shreg_q};
            addr_d       = addr_q + 1'b1;
            words_left_d = words_left_q - 1'b1;
            if (words_left_q == 8'd1) fstate_d = F_CSUM;
          end
        end
        F_CSUM: fstate_d = (shreg_q == csum_q) ? F_DONE : F_ERR;
        F_DONE, F_ERR: if (shreg_q == SYNC_BYTE) fstate_d = F_LEN;
        default: fstate_d = F_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rstate_q     <= R_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      brk_q        <= 1'b0;
      byte_valid_q <= 1'b0;
      fstate_q     <= F_SYNC;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      csum_q       <= '0;
      word_q       <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      rx_s1_q      <= rx;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      rstate_q     <= rstate_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      brk_q        <= brk_d;
      byte_valid_q <= byte_valid_d;
      fstate_q     <= fstate_d;
      words_left_q <= words_left_d;
      byte_idx_q   <= byte_idx_d;
      csum_q       <= csum_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign done      = (fstate_q == F_DONE);
  assign cpu_reset = (fstate_q == F_DONE);
  assign err       = (fstate_q == F_ERR);
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: UART frames at 4 clocks per bit, write log
// captured by a monitor, expectations hand-computed per scenario.
module tb_imem_loader;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_reset, done, err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  log_addr [0:63];
  logic [31:0] log_data [0:63];
  int wr_count = 0;
  int wr_run = 0;
  int wr_run_max = 0;

  logic [7:0] good_frame [0:10];

  imem_loader #(.CLKS_PER_BIT(CPB), .PC_ADDR_WIDTH(8), .WORD_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .rx(rx), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wr_count < 64) begin
        log_addr[wr_count] = wr_addr;
        log_data[wr_count] = wr_data;
      end
      wr_count = wr_count + 1;
      wr_run = wr_run + 1;
      if (wr_run > wr_run_max) wr_run_max = wr_run;
    end else begin
      wr_run = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_good_frame();
    for (int i = 0; i < 11; i++) send_byte(good_frame[i], 1'b1);
  endtask

  task automatic wait_done(input int max_cycles);
    for (int i = 0; i < max_cycles && done !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    checks++; if (wr_addr !== 8'd0) begin errors++; $display("FAIL reset_wr_addr: got %h expected 00", wr_addr); end
    checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL reset_cpu_reset: got %b expected 0", cpu_reset); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_load();
    int base;
    do_reset();
    base = wr_count;
    send_good_frame();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL good_done_early: got %b expected 0", done); end
    wait_done(10);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL good_done: got %b expected 1", done); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL good_cpu_reset: got %b expected 1", cpu_reset); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL good_err: got %b expected 0", err); end
    checks++; if (wr_count - base !== 2) begin errors++; $display("FAIL good_write_count: got %0d expected 2", wr_count - base); end
    checks++; if (log_addr[base] !== 8'd0 || log_data[base] !== 32'h20010005) begin
      errors++; $display("FAIL good_write0: got %h/%h expected 00/20010005", log_addr[base], log_data[base]); end
    checks++; if (log_addr[base+1] !== 8'd1 || log_data[base+1] !== 32'h8C020000) begin
      errors++; $display("FAIL good_write1: got %h/%h expected 01/8c020000", log_addr[base+1], log_data[base+1]); end
    repeat (20) @(negedge clk);
    checks++; if (done !== 1'b1 || cpu_reset !== 1'b1) begin
      errors++; $display("FAIL good_sticky: got done=%b cpu_reset=%b expected 1/1", done, cpu_reset); end
  endtask

  task automatic test_bad_checksum();
    int base;
    do_reset();
    base = wr_count;
    for (int i = 0; i < 10; i++) send_byte(good_frame[i], 1'b1);
    send_byte(8'h55, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (wr_count - base !== 2) begin errors++; $display("FAIL badcs_write_count: got %0d expected 2", wr_count - base); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL badcs_err: got %b expected 1", err); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL badcs_done: got %b expected 0", done); end
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL badcs_cpu_reset: got %b expected 0", cpu_reset); end
    send_good_frame();
    wait_done(10);
    checks++; if (done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL badcs_reload: got done=%b err=%b expected 1/0", done, err); end
    checks++; if (wr_count - base !== 4 || log_addr[base+2] !== 8'd0 || log_addr[base+3] !== 8'd1) begin
      errors++; $display("FAIL badcs_reload_addr: got n=%0d a=%h,%h expected 4 00,01", wr_count - base, log_addr[base+2], log_addr[base+3]); end
  endtask

  task automatic test_len_zero();
    int base;
    do_reset();
    base = wr_count;
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL len0_noise_err: got %b expected 0", err); end
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL len0_err: got %b expected 1", err); end
    checks++; if (wr_count - base !== 0) begin errors++; $display("FAIL len0_writes: got %0d expected 0", wr_count - base); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL len0_done: got %b expected 0", done); end
  endtask

  task automatic test_framing_error();
    int base;
    do_reset();
    base = wr_count;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ferr_err: got %b expected 1", err); end
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL ferr_cpu_reset: got %b expected 0", cpu_reset); end
    repeat (8) @(negedge clk);
    checks++; if (wr_count - base !== 0) begin errors++; $display("FAIL ferr_writes: got %0d expected 0", wr_count - base); end
    send_good_frame();
    wait_done(10);
    checks++; if (done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL ferr_recover: got done=%b err=%b expected 1/0", done, err); end
  endtask

  task automatic test_glitch();
    int base;
    do_reset();
    base = wr_count;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (err !== 1'b0 || done !== 1'b0 || cpu_reset !== 1'b0) begin
      errors++; $display("FAIL glitch_idle: got err=%b done=%b cpu_reset=%b expected 0/0/0", err, done, cpu_reset); end
    checks++; if (wr_count - base !== 0) begin errors++; $display("FAIL glitch_writes: got %0d expected 0", wr_count - base); end
    send_good_frame();
    wait_done(10);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL glitch_load_done: got %b expected 1", done); end
    checks++; if (wr_count - base !== 2 || log_data[base] !== 32'h20010005) begin
      errors++; $display("FAIL glitch_load_data: got n=%0d d=%h expected 2 20010005", wr_count - base, log_data[base]); end
  endtask

  task automatic test_reset_mid_load();
    int base;
    do_reset();
    base = wr_count;
    for (int i = 0; i < 7; i++) send_byte(good_frame[i], 1'b1);
    @(negedge clk);
    checks++; if (wr_count - base !== 1) begin errors++; $display("FAIL midrst_pre_writes: got %0d expected 1", wr_count - base); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (wr_en !== 1'b0 || wr_addr !== 8'd0 || wr_data !== 32'd0) begin
      errors++; $display("FAIL midrst_wr_port: got %b/%h/%h expected 0/00/00000000", wr_en, wr_addr, wr_data); end
    checks++; if (cpu_reset !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL midrst_status: got %b/%b/%b expected 0/0/0", cpu_reset, done, err); end
    reset = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (wr_count - base !== 1) begin errors++; $display("FAIL midrst_no_write: got %0d expected 1", wr_count - base); end
    send_good_frame();
    wait_done(10);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_reload_done: got %b expected 1", done); end
    checks++; if (wr_count - base !== 3 || log_addr[base+1] !== 8'd0 || log_data[base+1] !== 32'h20010005
                  || log_addr[base+2] !== 8'd1) begin
      errors++; $display("FAIL midrst_reload_writes: got n=%0d a=%h d=%h a=%h expected 3 00 20010005 01",
                         wr_count - base, log_addr[base+1], log_data[base+1], log_addr[base+2]); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = wr_count;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    checks++; if (done !== 1'b0 || cpu_reset !== 1'b0) begin
      errors++; $display("FAIL b2b_reload_hold: got done=%b cpu_reset=%b expected 0/0", done, cpu_reset); end
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'h22, 1'b1);
    wait_done(10);
    checks++; if (done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL b2b_done: got done=%b err=%b expected 1/0", done, err); end
    checks++; if (wr_count - base !== 1 || log_addr[base] !== 8'd0 || log_data[base] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL b2b_write: got n=%0d a=%h d=%h expected 1 00 deadbeef", wr_count - base, log_addr[base], log_data[base]); end
    checks++; if (wr_run_max !== 1) begin errors++; $display("FAIL wr_en_width: got %0d expected 1", wr_run_max); end
  endtask

  initial begin
    reset = 1'b0;
    rx = 1'b1;
    good_frame[0] = 8'hA5; good_frame[1] = 8'h02;
    good_frame[2] = 8'h20; good_frame[3] = 8'h01; good_frame[4] = 8'h00; good_frame[5] = 8'h05;
    good_frame[6] = 8'h8C; good_frame[7] = 8'h02; good_frame[8] = 8'h00; good_frame[9] = 8'h00;
    good_frame[10] = 8'hAA;
    @(negedge clk);
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_len_zero();
    test_framing_error();
    test_glitch();
    test_reset_mid_load();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
